// File: rtl/in_channel_if.sv
// Host-load / program-pop bundle for the input channel feeder.
// load_valid/load_ready: a word transfers on a rising edge where both are high; load_ready never depends on load_valid or in_req.
interface in_channel_if #(
    parameter int W = 12
);
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         in_req;
    logic [W-1:0] in_data;
    logic         in_ack;
    logic [W-1:0] in_size;
    logic [W-1:0] in_pos;
    logic         underflow;

    modport master (
        output load_valid, load_data, in_req,
        input  load_ready, in_data, in_ack, in_size, in_pos, underflow
    );

    modport slave (
        input  load_valid, load_data, in_req,
        output load_ready, in_data, in_ack, in_size, in_pos, underflow
    );
endinterface

// File: rtl/in_channel_feeder.sv
// Circular-buffer input channel: host loads words, the program pops them one per "in" request.
// Pops only see words stored before the edge, so an empty channel never bypasses a same-cycle load.
module in_channel_feeder #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn                = 8
) (
    input logic          clock,
    input logic          reset,
    in_channel_if.slave  ch
);
    localparam int W  = MemoryElementWidth;
    localparam int PW = $clog2(NIn);
    localparam int CW = $clog2(NIn + 1);
    localparam logic [PW-1:0] LastPtr = PW'(NIn - 1);
    localparam logic [CW-1:0] FullCnt = CW'(NIn);

    logic [W-1:0]  mem_q [NIn];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  in_data_q, in_data_d;
    logic          in_ack_q, in_ack_d;
    logic [W-1:0]  in_pos_q, in_pos_d;
    logic          underflow_q, underflow_d;

    logic load_ready;
    logic do_load;
    logic do_pop;
    logic empty;

    assign load_ready = (count_q < FullCnt);
    assign empty      = (count_q == '0);
    assign do_load    = ch.load_valid && load_ready && !reset;
    assign do_pop     = ch.in_req && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        in_data_d   = in_data_q;
        in_ack_d    = 1'b0;
        in_pos_d    = in_pos_q;
        underflow_d = underflow_q;

        if (do_load) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d  = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            in_data_d = mem_q[rd_ptr_q];
            in_ack_d  = 1'b1;
            in_pos_d  = in_pos_q + 1'b1;
        end
        if (ch.in_req && empty) begin
            underflow_d = 1'b1;
        end
        // Simultaneous load and pop cancel out in the occupancy count.
        if (do_load && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_load && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_data_q   <= '0;
            in_ack_q    <= 1'b0;
            in_pos_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_data_q   <= in_data_d;
            in_ack_q    <= in_ack_d;
            in_pos_q    <= in_pos_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers and count clear.
    always_ff @(posedge clock) begin
        if (do_load) begin
            mem_q[wr_ptr_q] <= ch.load_data;
        end
    end

    assign ch.load_ready = load_ready;
    assign ch.in_data    = in_data_q;
    assign ch.in_ack     = in_ack_q;
    assign ch.in_size    = W'(count_q);
    assign ch.in_pos     = in_pos_q;
    assign ch.underflow  = underflow_q;
endmodule

// File: tb/tb_in_channel_feeder.sv
// Self-checking bench for in_channel_feeder: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_in_channel_feeder;
    localparam int W = 12;
    localparam int N = 8;

    typedef struct {
        logic         lv;
        logic [W-1:0] ld;
        logic         rq;
        logic [W-1:0] e_data;
        logic         e_ack;
        logic [W-1:0] e_size;
        logic [W-1:0] e_pos;
        logic         e_uf;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    in_channel_if #(.W(W)) ch ();

    in_channel_feeder #(.MemoryElementWidth(W), .NIn(N)) dut (
        .clock (clock),
        .reset (reset),
        .ch    (ch)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0] exp_q [$];
    logic [W-1:0] m_data;
    logic         m_ack;
    logic [W-1:0] m_pos;
    logic         m_uf;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("in_data",   32'(ch.in_data),   32'(m_data));
        chk("in_ack",    32'(ch.in_ack),    32'(m_ack));
        chk("in_size",   32'(ch.in_size),   32'(exp_q.size()));
        chk("in_pos",    32'(ch.in_pos),    32'(m_pos));
        chk("underflow", 32'(ch.underflow), 32'(m_uf));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic lv, input logic [W-1:0] ld, input logic rq);
        bit pop;
        bit acc;
        @(negedge clock);
        ch.load_valid = lv;
        ch.load_data  = ld;
        ch.in_req     = rq;
        #1;
        chk("load_ready", 32'(ch.load_ready), 32'(exp_q.size() < N));
        pop = rq && (exp_q.size() > 0);
        acc = lv && (exp_q.size() < N);
        if (rq && exp_q.size() == 0) m_uf = 1'b1;
        m_ack = pop;
        if (pop) begin
            m_data = exp_q.pop_front();
            m_pos  = m_pos + 1'b1;
        end
        if (acc) exp_q.push_back(ld);
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b1;
        ch.load_valid = 1'b1;
        ch.load_data  = W'($urandom);
        ch.in_req     = 1'b1;
        @(posedge clock);
        #1;
        exp_q.delete();
        m_data = '0;
        m_ack  = 1'b0;
        m_pos  = '0;
        m_uf   = 1'b0;
        @(negedge clock);
        reset         = 1'b0;
        ch.load_valid = 1'b0;
        ch.in_req     = 1'b0;
        #1;
        check_model();
        chk("load_ready_after_reset", 32'(ch.load_ready), 32'd1);
    endtask

    // ---------------- test ----------------
    vec_t vt [10];

    initial begin
        ch.load_valid = 1'b0;
        ch.load_data  = '0;
        ch.in_req     = 1'b0;

        //           lv  ld   rq  data ack size pos uf
        vt[0] = '{1'b1, 12'd88, 1'b0, 12'd0,  1'b0, 12'd1, 12'd0, 1'b0};
        vt[1] = '{1'b1, 12'd44, 1'b0, 12'd0,  1'b0, 12'd2, 12'd0, 1'b0};
        vt[2] = '{1'b0, 12'd0,  1'b1, 12'd88, 1'b1, 12'd1, 12'd1, 1'b0};
        vt[3] = '{1'b0, 12'd0,  1'b0, 12'd88, 1'b0, 12'd1, 12'd1, 1'b0};
        vt[4] = '{1'b0, 12'd0,  1'b1, 12'd44, 1'b1, 12'd0, 12'd2, 1'b0};
        vt[5] = '{1'b0, 12'd0,  1'b1, 12'd44, 1'b0, 12'd0, 12'd2, 1'b1};
        vt[6] = '{1'b1, 12'd5,  1'b0, 12'd44, 1'b0, 12'd1, 12'd2, 1'b1};
        vt[7] = '{1'b0, 12'd0,  1'b1, 12'd5,  1'b1, 12'd0, 12'd3, 1'b1};
        vt[8] = '{1'b1, 12'd7,  1'b1, 12'd5,  1'b0, 12'd1, 12'd3, 1'b1};
        vt[9] = '{1'b0, 12'd0,  1'b1, 12'd7,  1'b1, 12'd0, 12'd4, 1'b1};

        repeat (2) @(posedge clock);
        do_reset();

        // Directed table: basic load/pop, underflow stickiness, no bypass on empty.
        for (int i = 0; i < 10; i++) begin
            step(vt[i].lv, vt[i].ld, vt[i].rq);
            chk($sformatf("tbl%0d_data", i), 32'(ch.in_data),   32'(vt[i].e_data));
            chk($sformatf("tbl%0d_ack", i),  32'(ch.in_ack),    32'(vt[i].e_ack));
            chk($sformatf("tbl%0d_size", i), 32'(ch.in_size),   32'(vt[i].e_size));
            chk($sformatf("tbl%0d_pos", i),  32'(ch.in_pos),    32'(vt[i].e_pos));
            chk($sformatf("tbl%0d_uf", i),   32'(ch.underflow), 32'(vt[i].e_uf));
        end

        // Fill past capacity with load_valid held, then drain in order.
        do_reset();
        for (int i = 0; i < N + 1; i++) step(1'b1, W'(100 + i), 1'b0);
        chk("full_size", 32'(ch.in_size), 32'(N));
        chk("full_ready", 32'(ch.load_ready), 32'd0);
        for (int i = 0; i < N; i++) begin
            step(1'b0, '0, 1'b1);
            chk($sformatf("drain%0d", i), 32'(ch.in_data), 32'(100 + i));
        end
        chk("drained_size", 32'(ch.in_size), 32'd0);
        chk("drained_uf", 32'(ch.underflow), 32'd0);

        // Steady-state streaming at occupancy 3 across pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, W'(200 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, W'(203 + i), 1'b1);
            chk("stream_size", 32'(ch.in_size), 32'd3);
            chk("stream_data", 32'(ch.in_data), 32'(200 + i));
        end

        // Full plus simultaneous load/pop: only the pop happens.
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, W'(300 + i), 1'b0);
        step(1'b1, W'(999), 1'b1);
        chk("full_both_size", 32'(ch.in_size), 32'(N - 1));
        for (int i = 0; i < N - 1; i++) step(1'b0, '0, 1'b1);
        chk("full_both_last", 32'(ch.in_data), 32'(300 + N - 1));
        step(1'b1, W'(55), 1'b1);
        chk("empty_both_uf", 32'(ch.underflow), 32'd1);
        chk("empty_both_size", 32'(ch.in_size), 32'd1);

        // Mid-operation reset discards buffered words.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, W'(400 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        do_reset();
        chk("rst_size", 32'(ch.in_size), 32'd0);
        chk("rst_pos", 32'(ch.in_pos), 32'd0);
        chk("rst_uf", 32'(ch.underflow), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("rst_pop_uf", 32'(ch.underflow), 32'd1);
        chk("rst_pop_ack", 32'(ch.in_ack), 32'd0);

        // Randomized traffic with varying load/pop pressure and rare resets.
        for (int blk = 0; blk < 8; blk++) begin
            int p_load;
            int p_pop;
            p_load = $urandom_range(10, 95);
            p_pop  = $urandom_range(10, 95);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    do_reset();
                end else begin
                    step($urandom_range(0, 99) < p_load, W'($urandom), $urandom_range(0, 99) < p_pop);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/in_channel_feeder.md
IN_CHANNEL_FEEDER -- requirements
Module: in_channel_feeder

Interface
REQ-001 Parameter MemoryElementWidth, default 12, SHALL set data width W of every channel word.
REQ-002 Parameter NIn, default 8, SHALL set channel depth in words; any integer value 2..256 SHALL be supported.
REQ-003 clock  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 load_valid  input  1  SHALL mean the host offers load_data this cycle.
REQ-006 load_data  input  W  SHALL carry the host word.
REQ-007 load_ready  output  1  SHALL mean the channel can accept a word this cycle.
REQ-008 in_req  input  1  SHALL mean the program executes an "in" instruction (pop request).
REQ-009 in_data  output  W  SHALL carry the most recently delivered word.
REQ-010 in_ack  output  1  SHALL pulse for one cycle when in_data was updated by a pop.
REQ-011 in_size  output  W  SHALL equal the number of words loaded but not yet popped (the "inSize" result).
REQ-012 in_pos  output  W  SHALL count words popped since reset, wrapping modulo 2^W.
REQ-013 underflow  output  1  SHALL be a sticky flag set by a pop request on an empty channel.

Function
REQ-014 Storage SHALL be a circular buffer of NIn words with write pointer, read pointer and occupancy count; pointers SHALL wrap from NIn-1 to 0.
REQ-015 load_ready SHALL be combinational: high iff count < NIn, independent of in_req in the same cycle.
REQ-016 A load SHALL occur on a rising edge with load_valid and load_ready both high: word written at write pointer, write pointer advances, count +1.
REQ-017 load_valid while load_ready is low SHALL be ignored; no word stored, no state change.
REQ-018 A pop SHALL occur on a rising edge with in_req high and count > 0 before that edge; in_data takes the word at the read pointer, the read pointer advances, count -1, in_pos +1, and in_ack is high for the following cycle only.
REQ-019 in_req with count = 0 SHALL leave in_data, pointers, count and in_pos unchanged, keep in_ack low, and set underflow.
REQ-020 A simultaneous load and pop in one cycle SHALL leave count unchanged, with both pointers advancing.
REQ-021 With count = 0, a simultaneous load and in_req SHALL NOT bypass: the request underflows, the word is stored, count becomes 1.
REQ-022 With count = NIn, a simultaneous load and pop SHALL perform only the pop; the offered word is not accepted (load_ready was low).
REQ-023 in_size SHALL be driven from the count register, reflecting every load and pop one cycle after the edge that performs it.
REQ-024 in_data SHALL hold its value between pops; words SHALL be delivered in load order.
REQ-025 Pop latency SHALL be one cycle: in_req sampled at edge N, in_data/in_ack valid after edge N.

Reset
REQ-026 While reset is high at a rising edge, the block SHALL clear count, both pointers, in_pos, in_data, in_ack and underflow to 0; load and pop SHALL be ignored that cycle.
REQ-027 After reset, load_ready SHALL be 1 and in_size 0; buffer contents SHALL be don't-care and SHALL never be observable before being reloaded.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; the next pop before any load SHALL underflow.

Verification
REQ-029 Load 88 then 44 -> in_size 2; pop -> in_data 88, in_ack 1 for one cycle, in_size 1, in_pos 1; pop -> in_data 44, in_size 0, in_pos 2.
REQ-030 From empty, pop -> underflow 1, in_ack 0, in_data holds 44; underflow stays 1 through later successful loads and pops until reset.
REQ-031 NIn=8: load 8 words with load_valid held -> load_ready drops after the 8th, 9th word not stored, in_size 8; pop all 8 -> same order, in_size 0.
REQ-032 Hold in_size at 3, then assert load and pop together for 5 cycles -> in_size stays 3, data popped in exact load order; continue through 20 total words to cover pointer wrap.
REQ-033 Full channel plus simultaneous load and pop -> in_size 7, offered word not stored; empty channel plus simultaneous load and pop -> underflow 1, in_size 1.
REQ-034 Load 5 words, pop 2, assert reset one cycle -> in_size 0, in_pos 0, underflow 0, load_ready 1; pop -> underflow 1.
